// File: rtl/iommu_wsi_pkg.sv
// Shared types and constants for the IOMMU wired-signalled interrupt generator.
// The optional re-pulse behaviour is selected by IOMMU_WSI_REPULSE_EN (see iommu_wsi_gen).
package iommu_wsi_pkg;

   typedef enum logic [1:0] {
      CQ  = 2'd0,
      FQ  = 2'd1,
      HPM = 2'd2,
      PQ  = 2'd3
   } src_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      GAP    = 2'd2
   } wire_state_e;

   localparam int unsigned NUM_LEGAL_WIRES = 5;
   localparam int unsigned LEGAL_WIRES [NUM_LEGAL_WIRES] = '{1, 2, 4, 8, 16};

   function automatic bit wires_legal(input int unsigned n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < NUM_LEGAL_WIRES; i++)
         if (LEGAL_WIRES[i] == n) ok = 1'b1;
      return ok;
   endfunction

endpackage

// File: rtl/iommu_wsi_wire_fsm.sv
// One interrupt wire: level output with a guaranteed low gap after every fall.
// Requests seen during the gap are held off until it expires, never dropped.
import iommu_wsi_pkg::*;

module iommu_wsi_wire_fsm #(
   parameter int unsigned GapCycles = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_req,
   input  logic i_repulse,
   output logic o_wire
);

   localparam int unsigned     CntW    = $clog2(GapCycles + 1);
   localparam logic [CntW-1:0] CntLoad = CntW'(GapCycles - 1);

   wire_state_e     r_state;
   logic [CntW-1:0] r_cnt;
   logic            r_wire;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_wire  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_req) begin
                  r_state <= ASSERT;
                  r_wire  <= 1'b1;
               end
            end
            ASSERT: begin
               // A re-pulse takes the same path as a drop so the low time is identical.
               if (!i_req || i_repulse) begin
                  r_state <= GAP;
                  r_cnt   <= CntLoad;
                  r_wire  <= 1'b0;
               end
            end
            GAP: begin
               if (r_cnt == '0) begin
                  if (i_req) begin
                     r_state <= ASSERT;
                     r_wire  <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_wire  <= 1'b0;
            end
         endcase
      end
   end

   assign o_wire = r_wire;

endmodule

// File: rtl/iommu_wsi_gen.sv
// IOMMU WSI transmitter: pending bits per source, routed by vector onto PLIC wires.
// Define IOMMU_WSI_REPULSE_EN to re-pulse an asserted wire on a fresh event.
import iommu_wsi_pkg::*;

module iommu_wsi_gen #(
   parameter int unsigned NumWires  = 4,
   parameter int unsigned NumSrc    = 4,
   parameter int unsigned GapCycles = 2,
   parameter int unsigned VecW      = (NumWires > 1) ? $clog2(NumWires) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         wsi_en_i,
   input  logic [NumSrc-1:0]            src_event_i,
   input  logic [NumSrc-1:0]            src_ie_i,
   input  logic [NumSrc-1:0][VecW-1:0]  src_vec_i,
   input  logic [NumSrc-1:0]            pend_clr_i,
   output logic [NumSrc-1:0]            pend_o,
   output logic [NumWires-1:0]          wsi_o
);

   logic [NumSrc-1:0]   r_pend;
   logic [NumWires-1:0] w_req;
   logic [NumWires-1:0] w_rep;

   // Set wins over a same-cycle clear.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_pend <= '0;
      else         r_pend <= (r_pend & ~pend_clr_i) | src_event_i;
   end

   always_comb begin
      w_req = '0;
      w_rep = '0;
      for (int w = 0; w < NumWires; w++) begin
         for (int s = 0; s < NumSrc; s++) begin
            if (r_pend[s] && src_ie_i[s] &&
                ((NumWires == 1) || (src_vec_i[s] == VecW'(w)))) begin
               w_req[w] = 1'b1;
`ifdef IOMMU_WSI_REPULSE_EN
               w_rep[w] = w_rep[w] | src_event_i[s];
`endif
            end
         end
      end
      w_req = w_req & {NumWires{wsi_en_i}};
   end

   for (genvar w = 0; w < NumWires; w++) begin : g_wire
      iommu_wsi_wire_fsm #(
         .GapCycles (GapCycles)
      ) u_fsm (
         .i_clk     (clk_i),
         .i_rst_n   (rst_ni),
         .i_req     (w_req[w]),
         .i_repulse (w_rep[w]),
         .o_wire    (wsi_o[w])
      );
   end

   assign pend_o = r_pend;

endmodule

// File: tb/tb_iommu_wsi_gen.sv
// Directed plus randomized bench for iommu_wsi_gen against a low-time reference model.
module tb_iommu_wsi_gen;

   localparam int NW = 4;
   localparam int NS = 4;
   localparam int G  = 2;
   localparam int VW = 2;
   localparam bit REP =
`ifdef IOMMU_WSI_REPULSE_EN
      1'b1;
`else
      1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst_n, en;
   logic [NS-1:0]         ev, ie, clr;
   logic [NS-1:0][VW-1:0] vec;
   logic [NS-1:0]         pend;
   logic [NW-1:0]         wsi;

   int checks = 0;
   int errors = 0;

   // Model: pending set, and per wire the number of cycles it has been low since its last fall.
   logic [NS-1:0] m_pend;
   logic [NW-1:0] m_wsi;
   int            m_low [NW];

   iommu_wsi_gen #(
      .NumWires (NW), .NumSrc (NS), .GapCycles (G)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .wsi_en_i    (en),
      .src_event_i (ev),
      .src_ie_i    (ie),
      .src_vec_i   (vec),
      .pend_clr_i  (clr),
      .pend_o      (pend),
      .wsi_o       (wsi)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [NW-1:0] req, rep, nxt;
      req = '0; rep = '0; nxt = '0;
      if (!rst_n) begin
         m_pend = '0;
         m_wsi  = '0;
         for (int w = 0; w < NW; w++) m_low[w] = G;
      end else begin
         for (int s = 0; s < NS; s++) begin
            if (m_pend[s] && ie[s]) begin
               if (en) req[vec[s]] = 1'b1;
               if (ev[s]) rep[vec[s]] = 1'b1;
            end
         end
         for (int w = 0; w < NW; w++) begin
            if (m_wsi[w]) begin
               nxt[w] = req[w] && !(REP && rep[w]);
               if (!nxt[w]) m_low[w] = 0;
            end else begin
               if (m_low[w] < G) m_low[w]++;
               nxt[w] = req[w] && (m_low[w] >= G);
            end
         end
         m_pend = (m_pend & ~clr) | ev;
         m_wsi  = nxt;
      end
      @(posedge clk);
      #1;
      chk("model_pend", 32'(pend), 32'(m_pend));
      chk("model_wsi", 32'(wsi), 32'(m_wsi));
   endtask

   task automatic idle(input int n);
      ev = '0; clr = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; ev = '0; ie = '1; clr = '0;
      vec = {2'd3, 2'd1, 2'd2, 2'd0};
      for (int i = 0; i < 3; i++) tick();
      chk("rst_pend", 32'(pend), 32'h0);
      chk("rst_wsi", 32'(wsi), 32'h0);
      rst_n = 1'b1;
      idle(5);

      ev = 4'b0010; tick(); ev = '0;
      chk("fq_pend", 32'(pend), 32'h2);
      chk("fq_wsi_lat1", 32'(wsi), 32'h0);
      tick();
      chk("fq_wsi", 32'(wsi), 32'h4);
      idle(6);

      clr = 4'b0010; tick(); clr = '0;
      chk("clr_pend", 32'(pend), 32'h0);
      chk("clr_wsi_hold", 32'(wsi), 32'h4);
      tick();
      chk("clr_wsi_low", 32'(wsi), 32'h0);
      ev = 4'b0010; tick(); ev = '0;
      chk("gap_low", 32'(wsi), 32'h0);
      tick();
      chk("gap_rise", 32'(wsi), 32'h4);
      clr = 4'b0010; tick(); clr = '0;
      idle(4);

      vec[0] = 2'd1; vec[2] = 2'd1;
      ev = 4'b0101; tick(); ev = '0; tick();
      chk("share_wsi", 32'(wsi), 32'h2);
      clr = 4'b0001; tick(); clr = '0; tick();
      chk("share_hold", 32'(wsi), 32'h2);
      chk("share_pend", 32'(pend), 32'h4);
      clr = 4'b0100; tick(); clr = '0; tick();
      chk("share_fall", 32'(wsi), 32'h0);
      vec[0] = 2'd0;
      idle(3);

      ie[3] = 1'b0;
      ev = 4'b1000; clr = 4'b1000; tick(); ev = '0; clr = '0;
      chk("set_wins", 32'(pend), 32'h8);
      tick();
      chk("ie_off_wsi", 32'(wsi), 32'h0);
      chk("ie_off_pend", 32'(pend), 32'h8);
      clr = 4'b1000; tick(); clr = '0; ie = '1;
      idle(3);

      ev = 4'b0001; tick(); ev = '0; tick();
      chk("cq_wsi", 32'(wsi), 32'h1);
      idle(2);
      en = 1'b0; tick();
      chk("en_off_wsi", 32'(wsi), 32'h0);
      chk("en_off_pend", 32'(pend), 32'h1);
      en = 1'b1; tick();
      chk("reen_gap", 32'(wsi), 32'h0);
      tick();
      chk("reen_rise", 32'(wsi), 32'h1);
      idle(2);

      ev = 4'b0001; tick(); ev = '0;
      chk("repulse_1", 32'(wsi), REP ? 32'h0 : 32'h1);
      tick();
      chk("repulse_2", 32'(wsi), REP ? 32'h0 : 32'h1);
      tick();
      chk("repulse_3", 32'(wsi), 32'h1);

      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         en    = ($urandom_range(0, 15) != 0);
         ev    = 4'($urandom) & 4'($urandom) & 4'($urandom);
         clr   = 4'($urandom) & 4'($urandom) & 4'($urandom);
         ie    = ~(4'($urandom) & 4'($urandom) & 4'($urandom));
         if ($urandom_range(0, 9) == 0) vec = 8'($urandom);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
